ysyx_22041412_csr_ctrl: RTL and testbench
=========================================

# ysyx_22041412_csr_ctrl

Sequencer between the EXU and the machine-mode CSR file. Accepts one system request at a time (CSR read-modify-write, `ecall`, `mret`) plus the machine-timer interrupt. Breaks each request into single CSR-file transactions over a valid/ready port. Returns the old CSR value or a PC redirect to the EXU.

## Interface
Parameters:
- `XLEN`, 64, data/PC width
- `BAD_RDATA`, 64'h0, `rd_data` returned for illegal requests

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock; synchronous, active-high
- `req_valid`  in  1  EXU request; held with operands until `req_ready`
- `req_kind`  in  2  0 CSR op, 1 `ecall`, 2 `mret`, 3 illegal
- `req_pc`  in  XLEN  PC of the system instruction
- `req_addr`  in  3  CSR index: 2 mstatus, 3 mtvec, 4 mepc, 5 mcause
- `req_func3`  in  3  CSR funct3
- `req_wdata`  in  XLEN  rs1 value or zero-extended zimm
- `req_ready`  out  1  one-cycle completion pulse
- `rd_data`  out  XLEN  old CSR value; valid with `req_ready`
- `redirect_valid`  out  1  one-cycle pulse: fetch from `redirect_pc`
- `redirect_pc`  out  XLEN  target PC
- `irq_timer`  in  1  level machine-timer pending
- `irq_pc`  in  XLEN  PC of the next unexecuted instruction
- `irq_ack`  out  1  one-cycle pulse when the interrupt trap completes
- `csr_valid`  out  1  transaction request to the CSR file
- `csr_we`  out  1  1 write, 0 read
- `csr_addr`  out  3  CSR index
- `csr_wdata`  out  XLEN  write data
- `csr_rdata`  in  XLEN  read data; valid with `csr_ready`
- `csr_ready`  in  1  transaction-done pulse

## Operation
States:
- `IDLE`
- CSR op: `OP_RD`, `OP_WR`
- Trap (shared by `ecall` and the timer interrupt): `TR_EPC`, `TR_CAUSE`, `TR_SRD`, `TR_SWR`, `TR_VEC`
- `mret`: `RT_SRD`, `RT_SWR`, `RT_EPC`
- `DONE`

Dispatch from `IDLE`:
- Interrupt priority: `irq_timer && mie_shadow` takes priority over a pending `req_valid`. It enters the trap sequence with epc=`irq_pc` and cause=64'h8000_0000_0000_0007.
- `req_kind`=1 enters the trap sequence with epc=`req_pc` and cause=64'd11.
- Illegal requests:
  - Covered cases: `req_kind`=3; kind 0 with `req_func3[1:0]`=00; kind 0 with `req_addr` outside 2..5.
  - Response: `req_ready` in the next cycle with `rd_data`=`BAD_RDATA`, no CSR transaction.

CSR op:
- `OP_RD` reads `req_addr` and latches the old value.
- `OP_WR` writes new = func3[1:0] 01: wdata; 10: old|wdata; 11: old&~wdata.
- The write is skipped when func3[1]=1 and `req_wdata`=0.
- `DONE` follows: `req_ready` pulses with `rd_data`=old.

Trap sequence:
- `TR_EPC` writes mepc=epc.
- `TR_CAUSE` writes mcause=cause.
- `TR_SRD` reads mstatus.
- `TR_SWR` writes mstatus with MPIE←MIE, MIE←0, MPP←2'b11.
- `TR_VEC` reads mtvec.
- `DONE` pulses `redirect_valid`, with `redirect_pc`={mtvec[63:2],2'b00}. It also pulses `req_ready` for `ecall` or `irq_ack` for an interrupt.

`mret`:
- `RT_SRD` reads mstatus.
- `RT_SWR` writes MIE←MPIE, MPIE←1, MPP←2'b11.
- `RT_EPC` reads mepc.
- `DONE` pulses `redirect_valid`, with `redirect_pc`=mepc, and pulses `req_ready`.

`mie_shadow`:
- Resets to 0.
- Reloads bit 3 of every value written to mstatus, on any path.

## Timing
- Reset values: every output 0, state `IDLE`, `mie_shadow`=0, latches 0.
- `IDLE` → first state in 1 cycle. Operands are latched at dispatch; later changes on `req_*` are ignored.
- CSR handshake:
  - `csr_valid`, `csr_we`, `csr_addr` and `csr_wdata` are held stable from assertion until the cycle `csr_ready`=1.
  - The state advances on that edge.
  - `csr_valid` is low for at least 1 cycle between transactions.
  - `csr_ready` while `csr_valid`=0 is ignored.
- Latency with a 1-cycle-ready CSR file, dispatch edge to done pulse:
  - CSR op: 5 cycles; 3 when the write is skipped.
  - Trap: 11 cycles.
  - `mret`: 7 cycles.
  - Illegal: 2 cycles.
- `DONE` lasts 1 cycle, then `IDLE`.
- A new request may be dispatched in the cycle after `DONE`; `req_valid` must drop in the cycle after `req_ready`.
- The interrupt is sampled only in `IDLE`; `irq_timer` changes mid-sequence have no effect.
- `rst` in any state returns to `IDLE` on the next edge and drops the transaction in flight. No completion or redirect pulse is issued.

## Structure
- Package `ysyx_22041412_csr_pkg` holds:
  - CSR index constants: MSTATUS=2, MTVEC=3, MEPC=4, MCAUSE=5
  - `req_kind` enum
  - Cause constants: ECALL_M=11, IRQ_MTIMER=64'h8000_0000_0000_0007
  - mstatus bit positions: MIE=3, MPIE=7, MPP=12:11
  - State enum
- Sub-module `ysyx_22041412_csr_alu` (combinational) contains the write/set/clear merge and the trap-entry and `mret` mstatus transforms.

## Test plan
- CSR op: mstatus=64'ha00001800, CSRRS addr 2 wdata 8 → `rd_data`=64'ha00001800, mstatus=64'ha00001808, `mie_shadow`=1.
- Skipped write: CSRRC addr 5 wdata 0 → read only, no write transaction, `req_ready` 3 cycles after dispatch.
- `ecall`: pc=64'h8000_0010, mtvec=64'h8000_0100 → mepc=64'h8000_0010, mcause=11, mstatus MIE=0 MPIE=old MIE, redirect to 64'h8000_0100.
- `mret`: mepc=64'h8000_0014, mstatus MPIE=1 → MIE=1, MPIE=1, redirect to 64'h8000_0014.
- Interrupt priority:
  - Setup: `mie_shadow`=1, `irq_timer`=1 and `req_valid`=1 in the same cycle.
  - Response: trap with mcause=64'h8000_0000_0000_0007 and mepc=`irq_pc`, then `irq_ack`.
  - The request is serviced afterwards.
- Reset mid-operation: `csr_ready` stalled 5 cycles, `rst` asserted during `TR_SWR` → all outputs 0 next cycle, no redirect; a subsequent `ecall` completes normally.

Source files
------------

// File: rtl/ysyx_22041412_csr_pkg.sv
// Shared constants and types for the machine-mode CSR sequencer.
// Covers CSR indices, request kinds, trap causes, mstatus bit positions and FSM states.
package ysyx_22041412_csr_pkg;

    localparam logic [2:0] CSR_MSTATUS = 3'd2;
    localparam logic [2:0] CSR_MTVEC   = 3'd3;
    localparam logic [2:0] CSR_MEPC    = 3'd4;
    localparam logic [2:0] CSR_MCAUSE  = 3'd5;

    typedef enum logic [1:0] {
        KIND_CSR   = 2'd0,
        KIND_ECALL = 2'd1,
        KIND_MRET  = 2'd2,
        KIND_ILL   = 2'd3
    } req_kind_t;

    localparam logic [63:0] CAUSE_ECALL_M    = 64'd11;
    localparam logic [63:0] CAUSE_IRQ_MTIMER = 64'h8000_0000_0000_0007;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef enum logic [3:0] {
        IDLE,
        OP_RD,
        OP_WR,
        TR_EPC,
        TR_CAUSE,
        TR_SRD,
        TR_SWR,
        TR_VEC,
        RT_SRD,
        RT_SWR,
        RT_EPC,
        DONE
    } state_t;

    function automatic logic csr_addr_ok(input logic [2:0] addr);
        return (addr >= CSR_MSTATUS) && (addr <= CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/ysyx_22041412_csr_alu.sv
// Combinational CSR data transforms: write/set/clear merge, trap-entry and mret mstatus updates.
// Zero latency, no handshake; results follow the inputs within the same cycle.
module ysyx_22041412_csr_alu
    import ysyx_22041412_csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] merged,
    output logic [XLEN-1:0] trap_status,
    output logic [XLEN-1:0] mret_status
);

    always_comb begin
        case (op)
            2'b01:   merged = src;
            2'b10:   merged = old | src;
            2'b11:   merged = old & ~src;
            default: merged = old;
        endcase

        trap_status                       = old;
        trap_status[MS_MPIE]              = old[MS_MIE];
        trap_status[MS_MIE]               = 1'b0;
        trap_status[MS_MPP_HI:MS_MPP_LO]  = 2'b11;

        mret_status                       = old;
        mret_status[MS_MIE]               = old[MS_MPIE];
        mret_status[MS_MPIE]              = 1'b1;
        mret_status[MS_MPP_HI:MS_MPP_LO]  = 2'b11;
    end

endmodule

// File: rtl/ysyx_22041412_csr_ctrl.sv
// Sequences CSR ops, ecall, mret and timer traps into single CSR-file transactions.
// Each transaction costs an idle gap cycle plus the CSR file's ready wait; stalls hold all csr_* outputs.
module ysyx_22041412_csr_ctrl
    import ysyx_22041412_csr_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] BAD_RDATA = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [1:0]      req_kind,
    input  logic [XLEN-1:0] req_pc,
    input  logic [2:0]      req_addr,
    input  logic [2:0]      req_func3,
    input  logic [XLEN-1:0] req_wdata,
    output logic            req_ready,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            irq_timer,
    input  logic [XLEN-1:0] irq_pc,
    output logic            irq_ack,
    output logic            csr_valid,
    output logic            csr_we,
    output logic [2:0]      csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_ready
);

    state_t          state, state_nxt;
    logic            issued;
    req_kind_t       kind_q;
    logic            irq_q;
    logic [2:0]      addr_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] wdata_q, epc_q, cause_q, old_q, target_q;
    logic            mie_shadow;

    logic            txn_state, txn_we, txn_done;
    logic [2:0]      txn_addr;
    logic [XLEN-1:0] txn_wdata;
    logic [XLEN-1:0] merged, trap_status, mret_status;
    logic            irq_take, dispatch, req_bad, skip_wr;
    logic            unused_func3_msb;

    assign unused_func3_msb = req_func3[2];

    assign irq_take = irq_timer && mie_shadow;
    assign dispatch = (state == IDLE) && (irq_take || req_valid);
    assign req_bad  = (req_kind == 2'd3) ||
                      ((req_kind == 2'd0) && ((req_func3[1:0] == 2'b00) || !csr_addr_ok(req_addr)));
    assign skip_wr  = op_q[1] && (wdata_q == '0);
    assign txn_done = issued && csr_ready;

    ysyx_22041412_csr_alu #(.XLEN(XLEN)) u_alu (
        .op          (op_q),
        .old         (old_q),
        .src         (wdata_q),
        .merged      (merged),
        .trap_status (trap_status),
        .mret_status (mret_status)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        txn_state      = 1'b0;
        txn_we         = 1'b0;
        txn_addr       = '0;
        txn_wdata      = '0;
        req_ready      = 1'b0;
        irq_ack        = 1'b0;
        rd_data        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (irq_take) state_nxt = TR_EPC;
                else if (req_valid) begin
                    case (req_kind)
                        2'd1:    state_nxt = TR_EPC;
                        2'd2:    state_nxt = RT_SRD;
                        default: state_nxt = OP_RD;
                    endcase
                end
            end
            // Illegal requests pass through OP_RD without ever issuing.
            OP_RD: begin
                txn_state = (kind_q == KIND_CSR);
                txn_addr  = addr_q;
                if (kind_q != KIND_CSR) state_nxt = DONE;
                else if (txn_done)      state_nxt = skip_wr ? DONE : OP_WR;
            end
            OP_WR: begin
                txn_state = 1'b1; txn_we = 1'b1; txn_addr = addr_q; txn_wdata = merged;
                if (txn_done) state_nxt = DONE;
            end
            TR_EPC: begin
                txn_state = 1'b1; txn_we = 1'b1; txn_addr = CSR_MEPC; txn_wdata = epc_q;
                if (txn_done) state_nxt = TR_CAUSE;
            end
            TR_CAUSE: begin
                txn_state = 1'b1; txn_we = 1'b1; txn_addr = CSR_MCAUSE; txn_wdata = cause_q;
                if (txn_done) state_nxt = TR_SRD;
            end
            TR_SRD: begin
                txn_state = 1'b1; txn_addr = CSR_MSTATUS;
                if (txn_done) state_nxt = TR_SWR;
            end
            TR_SWR: begin
                txn_state = 1'b1; txn_we = 1'b1; txn_addr = CSR_MSTATUS; txn_wdata = trap_status;
                if (txn_done) state_nxt = TR_VEC;
            end
            TR_VEC: begin
                txn_state = 1'b1; txn_addr = CSR_MTVEC;
                if (txn_done) state_nxt = DONE;
            end
            RT_SRD: begin
                txn_state = 1'b1; txn_addr = CSR_MSTATUS;
                if (txn_done) state_nxt = RT_SWR;
            end
            RT_SWR: begin
                txn_state = 1'b1; txn_we = 1'b1; txn_addr = CSR_MSTATUS; txn_wdata = mret_status;
                if (txn_done) state_nxt = RT_EPC;
            end
            RT_EPC: begin
                txn_state = 1'b1; txn_addr = CSR_MEPC;
                if (txn_done) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
                irq_ack   = irq_q;
                req_ready = !irq_q;
                if (kind_q == KIND_ILL)      rd_data = BAD_RDATA;
                else if (kind_q == KIND_CSR) rd_data = old_q;
                redirect_valid = (kind_q == KIND_ECALL) || (kind_q == KIND_MRET);
                if (kind_q == KIND_MRET)       redirect_pc = target_q;
                else if (kind_q == KIND_ECALL) redirect_pc = {target_q[XLEN-1:2], 2'b00};
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The transaction view is gated by issued so csr_* stay quiet in gap cycles.
    assign csr_valid = issued;
    assign csr_we    = issued && txn_we;
    assign csr_addr  = issued ? txn_addr : '0;
    assign csr_wdata = issued ? txn_wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued     <= 1'b0;
            kind_q     <= KIND_CSR;
            irq_q      <= 1'b0;
            addr_q     <= '0;
            op_q       <= '0;
            wdata_q    <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
            old_q      <= '0;
            target_q   <= '0;
            mie_shadow <= 1'b0;
        end else begin
            if (txn_done)                  issued <= 1'b0;
            else if (txn_state && !issued) issued <= 1'b1;

            if (dispatch) begin
                if (irq_take) begin
                    kind_q  <= KIND_ECALL;
                    irq_q   <= 1'b1;
                    epc_q   <= irq_pc;
                    cause_q <= XLEN'(CAUSE_IRQ_MTIMER);
                end else begin
                    kind_q  <= req_bad ? KIND_ILL : req_kind_t'(req_kind);
                    irq_q   <= 1'b0;
                    epc_q   <= req_pc;
                    cause_q <= XLEN'(CAUSE_ECALL_M);
                end
                addr_q  <= req_addr;
                op_q    <= req_func3[1:0];
                wdata_q <= req_wdata;
            end

            if (txn_done && !txn_we) begin
                if (state == TR_VEC || state == RT_EPC) target_q <= csr_rdata;
                else                                    old_q    <= csr_rdata;
            end

            if (txn_done && txn_we && (txn_addr == CSR_MSTATUS))
                mie_shadow <= txn_wdata[MS_MIE];
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_csr_ctrl.sv
// Directed bench for the CSR sequencer against a small CSR-file model with programmable ready stall.
module tb_ysyx_22041412_csr_ctrl;

    localparam logic [63:0] BAD = 64'hDEAD_0BAD_DEAD_0BAD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_kind = '0;
    logic [63:0] req_pc = '0;
    logic [2:0]  req_addr = '0;
    logic [2:0]  req_func3 = '0;
    logic [63:0] req_wdata = '0;
    logic        req_ready;
    logic [63:0] rd_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        irq_timer = 1'b0;
    logic [63:0] irq_pc = '0;
    logic        irq_ack;
    logic        csr_valid, csr_we, csr_ready;
    logic [2:0]  csr_addr;
    logic [63:0] csr_wdata, csr_rdata;

    logic [63:0] mem [0:7];
    int          wait_cnt = 0;
    int          wr_cnt = 0;
    int          txn_cnt = 0;
    int          stall = 0;
    logic        poke_en = 1'b0;
    logic [2:0]  poke_addr = '0;
    logic [63:0] poke_dat = '0;

    int n_checks = 0;
    int n_fail = 0;

    ysyx_22041412_csr_ctrl #(.XLEN(64), .BAD_RDATA(BAD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_kind(req_kind), .req_pc(req_pc), .req_addr(req_addr),
        .req_func3(req_func3), .req_wdata(req_wdata), .req_ready(req_ready), .rd_data(rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .irq_timer(irq_timer), .irq_pc(irq_pc), .irq_ack(irq_ack),
        .csr_valid(csr_valid), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_ready(csr_ready)
    );

    always #5 clk = ~clk;

    assign csr_ready = csr_valid && (wait_cnt >= stall);
    assign csr_rdata = mem[csr_addr];

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_dat;
        if (csr_valid && csr_ready) begin
            txn_cnt <= txn_cnt + 1;
            if (csr_we) begin
                mem[csr_addr] <= csr_wdata;
                wr_cnt <= wr_cnt + 1;
            end
        end
        if (csr_valid && !csr_ready) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [2:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_dat = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic [1:0] kind, input logic [2:0] addr,
                          input logic [2:0] f3, input logic [63:0] wd, input logic [63:0] pc,
                          input int exp_lat, input logic chk_rd, input logic [63:0] exp_rd,
                          input logic exp_redir, input logic [63:0] exp_pc);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_kind = kind; req_addr = addr;
        req_func3 = f3; req_wdata = wd; req_pc = pc;
        @(posedge clk);
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (req_ready) begin lat = i; break; end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (chk_rd) check({tag, "_rd"}, rd_data, exp_rd);
        check({tag, "_redir"}, {63'd0, redirect_valid}, {63'd0, exp_redir});
        check({tag, "_rpc"}, redirect_pc, exp_pc);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0, t0, lat, pulses;
        logic found, rr_early;

        for (int a = 0; a < 8; a++) poke(3'(a), 64'd0);
        poke(3'd2, 64'ha00001800);
        poke(3'd3, 64'h8000_0100);

        check("rst_ctl", {59'd0, req_ready, redirect_valid, irq_ack, csr_valid, csr_we}, 64'd0);
        check("rst_rd", rd_data, 64'd0);
        check("rst_rpc", redirect_pc, 64'd0);
        check("rst_caddr", {61'd0, csr_addr}, 64'd0);
        check("rst_cwd", csr_wdata, 64'd0);
        check("rst_mie", {63'd0, dut.mie_shadow}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // CSRRS mstatus |= 8
        do_req("csrrs", 2'd0, 3'd2, 3'b010, 64'd8, 64'h8000_0000, 5, 1'b1, 64'ha00001800, 1'b0, 64'd0);
        check("csrrs_mstatus", mem[2], 64'ha00001808);
        check("csrrs_mie", {63'd0, dut.mie_shadow}, 64'd1);

        // CSRRC mcause with zero mask: read only
        w0 = wr_cnt; t0 = txn_cnt;
        poke(3'd5, 64'h1234);
        do_req("skip", 2'd0, 3'd5, 3'b011, 64'd0, 64'h8000_0004, 3, 1'b1, 64'h1234, 1'b0, 64'd0);
        check("skip_wr", 64'(wr_cnt - w0), 64'd0);
        check("skip_txn", 64'(txn_cnt - t0), 64'd1);
        check("skip_mcause", mem[5], 64'h1234);

        do_req("ecall", 2'd1, 3'd0, 3'd0, 64'd0, 64'h8000_0010, 11, 1'b0, 64'd0, 1'b1, 64'h8000_0100);
        check("ecall_mepc", mem[4], 64'h8000_0010);
        check("ecall_mcause", mem[5], 64'd11);
        check("ecall_mstatus", mem[2], 64'ha00001880);
        check("ecall_mie", {63'd0, dut.mie_shadow}, 64'd0);

        poke(3'd4, 64'h8000_0014);
        do_req("mret", 2'd2, 3'd0, 3'd0, 64'd0, 64'h8000_0020, 7, 1'b0, 64'd0, 1'b1, 64'h8000_0014);
        check("mret_mstatus", mem[2], 64'ha00001888);
        check("mret_mie", {63'd0, dut.mie_shadow}, 64'd1);

        // Timer interrupt and CSRRW mcause arrive together; the interrupt wins.
        @(posedge clk); #1;
        irq_timer = 1'b1; irq_pc = 64'h8000_0200;
        req_valid = 1'b1; req_kind = 2'd0; req_addr = 3'd5; req_func3 = 3'b001;
        req_wdata = 64'h55; req_pc = 64'h8000_0040;
        @(posedge clk);
        lat = 0; rr_early = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (req_ready) rr_early = 1'b1;
            if (irq_ack) begin lat = i; break; end
        end
        check("irq_lat", 64'(lat), 64'd11);
        check("irq_no_rr", {63'd0, rr_early}, 64'd0);
        check("irq_redir", {63'd0, redirect_valid}, 64'd1);
        check("irq_rpc", redirect_pc, 64'h8000_0100);
        @(posedge clk); #1;
        irq_timer = 1'b0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (req_ready) begin lat = i; break; end
        end
        check("irq_req_lat", 64'(lat), 64'd6);
        check("irq_req_rd", rd_data, 64'h8000_0000_0000_0007);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("irq_mepc", mem[4], 64'h8000_0200);
        check("irq_mcause", mem[5], 64'h55);
        check("irq_mstatus", mem[2], 64'ha00001880);

        w0 = wr_cnt; t0 = txn_cnt;
        do_req("ill_kind", 2'd3, 3'd2, 3'b001, 64'd1, 64'h8000_0050, 2, 1'b1, BAD, 1'b0, 64'd0);
        do_req("ill_f3", 2'd0, 3'd2, 3'b100, 64'd1, 64'h8000_0054, 2, 1'b1, BAD, 1'b0, 64'd0);
        do_req("ill_addr", 2'd0, 3'd7, 3'b001, 64'd1, 64'h8000_0058, 2, 1'b1, BAD, 1'b0, 64'd0);
        check("ill_txn", 64'(txn_cnt - t0), 64'd0);
        check("ill_wr", 64'(wr_cnt - w0), 64'd0);

        // Reset while the trap's mstatus write is stalled.
        stall = 5;
        @(posedge clk); #1;
        req_valid = 1'b1; req_kind = 2'd1; req_pc = 64'h8000_0060;
        found = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (csr_valid && csr_we && csr_addr == 3'd2) begin found = 1'b1; break; end
        end
        check("rst_mid_reach", {63'd0, found}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ctl", {59'd0, req_ready, redirect_valid, irq_ack, csr_valid, csr_we}, 64'd0);
        check("rst_mid_bus", {61'd0, csr_addr} | csr_wdata | rd_data | redirect_pc, 64'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready || redirect_valid || irq_ack) pulses++;
        end
        check("rst_mid_pulses", 64'(pulses), 64'd0);
        check("rst_mid_mstatus", mem[2], 64'ha00001880);
        stall = 0;

        do_req("post_ecall", 2'd1, 3'd0, 3'd0, 64'd0, 64'h8000_0030, 11, 1'b0, 64'd0, 1'b1, 64'h8000_0100);
        check("post_mepc", mem[4], 64'h8000_0030);
        check("post_mcause", mem[5], 64'd11);
        check("post_mstatus", mem[2], 64'ha00001800);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
